count_display_7seg: RTL and testbench

- Consumer end of the 16-bit millisecond counter output.
- Samples a 16-bit binary count on a load strobe and converts it to 5-digit BCD with a sequential double-dabble engine (one bit per clock).
- Drives a multiplexed, active-low 5-digit seven-segment display from the converted value.
- Sits between the counter's Q bus and the board's display pins.

---
 rtl/count_display_7seg.sv | 194 +++++++++++++++++++
 tb/tb_count_display_7seg.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/count_display_7seg.sv
// count_display_7seg
//   Samples a 16-bit binary count on LOAD and converts it to five BCD digits
//   with a sequential double-dabble engine, one bit per clock (16 cycles).
//   The converted value drives a multiplexed, active-low 5-digit
//   seven-segment display.
//
// Parameters
//   REFRESH_DIV  clock cycles each digit stays lit (2..2^20)
//
// Ports
//   CLK   in   1   system clock, rising edge
//   RST   in   1   asynchronous active-low reset
//   Q_IN  in   16  binary count to convert
//   LOAD  in   1   conversion request (ignored while BUSY)
//   BUSY  out  1   conversion in progress
//   DONE  out  1   one-cycle pulse when BCD updates
//   BCD   out  20  {d4,d3,d2,d1,d0}, d0 = ones
//   SEG   out  7   {g,f,e,d,c,b,a}, active-low
//   AN    out  5   active-low one-hot digit enable, AN[0] = ones digit
//
// Build option
//   COUNT_DISPLAY_LZ_BLANK_EN  when defined, leading zero digits (k>=1) are
//                              blanked; digit 0 always shows.

module count_display_7seg #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] Q_IN,
    input  logic        LOAD,
    output logic        BUSY,
    output logic        DONE,
    output logic [19:0] BCD,
    output logic [6:0]  SEG,
    output logic [4:0]  AN
);

    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_DIV - 1);

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] shreg, shreg_nxt;
    logic [19:0] scratch, scratch_nxt;
    logic [19:0] adj;
    logic [3:0]  iter, iter_nxt;
    logic [19:0] bcd_nxt;
    logic        busy_nxt, done_nxt;

    // ------------------------------------------------------------------
    // Conversion FSM: next state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        // add-3 correction on every nibble >= 5, ahead of the shift
        adj = scratch;
        for (int unsigned i = 0; i < 5; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end

        state_nxt   = state;
        shreg_nxt   = shreg;
        scratch_nxt = scratch;
        iter_nxt    = iter;
        bcd_nxt     = BCD;
        busy_nxt    = 1'b0;
        done_nxt    = 1'b0;

        case (state)
            IDLE: begin
                if (LOAD) begin
                    shreg_nxt   = Q_IN;
                    scratch_nxt = '0;
                    iter_nxt    = '0;
                    busy_nxt    = 1'b1;
                    state_nxt   = CONV;
                end
            end
            CONV: begin
                scratch_nxt = {adj[18:0], shreg[15]};
                shreg_nxt   = {shreg[14:0], 1'b0};
                iter_nxt    = iter + 4'd1;
                busy_nxt    = 1'b1;
                if (iter == 4'd15) begin
                    // last shift: publish the completed value directly
                    bcd_nxt   = {adj[18:0], shreg[15]};
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            shreg   <= '0;
            scratch <= '0;
            iter    <= '0;
            BCD     <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            scratch <= scratch_nxt;
            iter    <= iter_nxt;
            BCD     <= bcd_nxt;
            BUSY    <= busy_nxt;
            DONE    <= done_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------
    logic [CW-1:0] refcnt;
    logic [2:0]    idx;
    logic [3:0]    cur_digit;
    logic [6:0]    seg_nxt;

    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        case (d)
            4'd0:    seg_enc = 7'b1000000;
            4'd1:    seg_enc = 7'b1111001;
            4'd2:    seg_enc = 7'b0100100;
            4'd3:    seg_enc = 7'b0110000;
            4'd4:    seg_enc = 7'b0011001;
            4'd5:    seg_enc = 7'b0010010;
            4'd6:    seg_enc = 7'b0000010;
            4'd7:    seg_enc = 7'b1111000;
            4'd8:    seg_enc = 7'b0000000;
            4'd9:    seg_enc = 7'b0010000;
            default: seg_enc = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        case (idx)
            3'd0:    cur_digit = BCD[3:0];
            3'd1:    cur_digit = BCD[7:4];
            3'd2:    cur_digit = BCD[11:8];
            3'd3:    cur_digit = BCD[15:12];
            3'd4:    cur_digit = BCD[19:16];
            default: cur_digit = 4'd0;
        endcase
    end

`ifdef COUNT_DISPLAY_LZ_BLANK_EN
    logic blank;

    // a digit is blank when it and every more significant digit is zero
    always_comb begin
        case (idx)
            3'd1:    blank = (BCD[19:4]  == '0);
            3'd2:    blank = (BCD[19:8]  == '0);
            3'd3:    blank = (BCD[19:12] == '0);
            3'd4:    blank = (BCD[19:16] == '0);
            default: blank = 1'b0;
        endcase
        seg_nxt = blank ? 7'b1111111 : seg_enc(cur_digit);
    end
`else
    always_comb begin
        seg_nxt = seg_enc(cur_digit);
    end
`endif

    // On each wrap the digit selected by idx is latched into AN/SEG and idx
    // advances, so the first refresh after reset lights digit 0.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            refcnt <= '0;
            idx    <= '0;
            AN     <= '1;
            SEG    <= '1;
        end else if (refcnt == REF_LAST) begin
            refcnt <= '0;
            AN     <= ~(5'b00001 << idx);
            SEG    <= seg_nxt;
            idx    <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
        end else begin
            refcnt <= refcnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_count_display_7seg.sv
module tb_count_display_7seg;

    logic        CLK;
    logic        RST;
    logic [15:0] Q_IN;
    logic        LOAD;
    logic        BUSY;
    logic        DONE;
    logic [19:0] BCD;
    logic [6:0]  SEG;
    logic [4:0]  AN;

    int checks   = 0;
    int failures = 0;

    logic [19:0] sb[$];

    count_display_7seg #(.REFRESH_DIV(4)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .Q_IN (Q_IN),
        .LOAD (LOAD),
        .BUSY (BUSY),
        .DONE (DONE),
        .BCD  (BCD),
        .SEG  (SEG),
        .AN   (AN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [19:0] to_bcd(input int unsigned v);
        logic [19:0] r;
        r = '0;
        for (int k = 0; k < 5; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] exp_seg(input logic [19:0] b, input int k);
        logic [6:0] tab [10];
        logic [3:0] d;
        logic [6:0] s;
        tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        d = b[4*k +: 4];
        s = tab[d];
`ifdef COUNT_DISPLAY_LZ_BLANK_EN
        if (k >= 1 && (b >> (4*k)) == 20'd0)
            s = 7'b1111111;
`endif
        return s;
    endfunction

    // One LOAD pulse; scoreboard entry pushed at the request, popped at DONE.
    task automatic do_conv(input int unsigned v);
        logic [19:0] prev;
        logic [19:0] e;
        int n;
        bit got;
        Q_IN = 16'(v);
        LOAD = 1'b1;
        sb.push_back(to_bcd(v));
        prev = BCD;
        step();
        LOAD = 1'b0;
        chk("busy_after_load", 32'(BUSY), 32'd1);
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            step();
            n++;
            if (DONE) got = 1'b1;
            else if (n == 8) chk("bcd_hold", 32'(BCD), 32'(prev));
        end
        chk("done_seen", 32'(got), 32'd1);
        chk("latency", 32'(n), 32'd16);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("bcd_result", 32'(BCD), 32'(e));
        end
        chk("busy_after_done", 32'(BUSY), 32'd0);
        step();
        chk("done_one_cycle", 32'(DONE), 32'd0);
    endtask

    // Align to the start of a digit-0 refresh, then walk all five digits.
    task automatic scan_check(input logic [19:0] b);
        int n;
        logic [4:0] ea;
        n = 0;
        while (AN == 5'b11110 && n < 30) begin step(); n++; end
        while (AN != 5'b11110 && n < 60) begin step(); n++; end
        chk("scan_sync", 32'(AN), 32'h1e);
        for (int k = 0; k < 5; k++) begin
            ea = ~(5'b00001 << k);
            chk($sformatf("an_d%0d", k), 32'(AN), 32'(ea));
            chk($sformatf("seg_d%0d", k), 32'(SEG), 32'(exp_seg(b, k)));
            step(); step(); step();
            chk($sformatf("an_hold_d%0d", k), 32'(AN), 32'(ea));
            step();
        end
    endtask

    initial begin
        int n;
        int dones;
        bit got;
        logic [19:0] e;

        RST  = 1'b0;
        LOAD = 1'b0;
        Q_IN = '0;

        // reset state
        step(); step(); step();
        chk("rst_bcd",  32'(BCD),  32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_an",   32'(AN),   32'h1f);
        chk("rst_seg",  32'(SEG),  32'h7f);
        RST = 1'b1;
        step(); step(); step();
        chk("an_before_first_refresh", 32'(AN), 32'h1f);
        step();
        chk("first_an",  32'(AN),  32'h1e);
        chk("first_seg", 32'(SEG), 32'h40);

        // conversions and scan
        do_conv(1234);
        scan_check(20'h01234);
        do_conv(65535);

        // reset mid-conversion
        Q_IN = 16'd777;
        LOAD = 1'b1;
        step();
        LOAD = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("pre_abort_busy", 32'(BUSY), 32'd1);
        RST = 1'b0;
        #1;
        chk("abort_bcd",  32'(BCD),  32'd0);
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_done", 32'(DONE), 32'd0);
        chk("abort_an",   32'(AN),   32'h1f);
        chk("abort_seg",  32'(SEG),  32'h7f);
        step(); step();
        RST = 1'b1;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (DONE) dones++;
        end
        chk("no_done_after_abort", 32'(dones), 32'd0);

        do_conv(0);
        scan_check(20'h00000);

        // LOAD held high; Q_IN change mid-conversion affects only the next one
        Q_IN = 16'd9999;
        LOAD = 1'b1;
        sb.push_back(to_bcd(9999));
        step();
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            step();
            n++;
            if (n == 5) begin
                Q_IN = 16'd42;
                sb.push_back(to_bcd(42));
            end
            if (DONE) got = 1'b1;
        end
        chk("cont1_latency", 32'(n), 32'd16);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("cont1_bcd", 32'(BCD), 32'(e));
        end
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            step();
            n++;
            if (n == 1) chk("cont2_accept", 32'(BUSY), 32'd1);
            if (DONE) got = 1'b1;
        end
        LOAD = 1'b0;
        chk("cont2_period", 32'(n), 32'd17);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("cont2_bcd", 32'(BCD), 32'(e));
        end
        step();
        chk("cont_idle", 32'(BUSY), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
